// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES InvCipher: one decryption round per clock behind a start/busy/done handshake.
// Reads the same expanded key schedule the encrypt core produces, unchanged.
module aes_inv_cipher_iter #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                  clks,
  input  logic                  reset,
  input  logic                  start,
  input  logic [0:127]          cipherText,
  input  logic [0:128*(Nr+1)-1] keys,
  output logic [0:127]          plainText,
  output logic                  busy,
  output logic                  done
);

  localparam int KW = $clog2(128 * (Nr + 1));

  // Inverse S-box, byte x at bits [8x +: 8].
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} state_t;

  state_t       state_reg, state_next;
  logic [0:127] st_reg, st_next;
  logic [0:127] plain_reg, plain_next;
  logic [3:0]   rnd_reg, rnd_next;
  logic         busy_reg, busy_next;
  logic         done_reg, done_next;

  logic [0:127]  round_key;
  logic [0:127]  sub_row;
  logic [0:127]  mix_in;
  logic [0:127]  mix_out;
  logic [KW-1:0] key_base;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One output byte of InvMixColumns: {0e,0b,0d,09} against the column rotated to this row.
  function automatic logic [7:0] inv_mix(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    logic [7:0] m0, m1, m2, m3;
    m0 = xt(xt(xt(a0))) ^ xt(xt(a0)) ^ xt(a0);
    m1 = xt(xt(xt(a1))) ^ xt(a1) ^ a1;
    m2 = xt(xt(xt(a2))) ^ xt(xt(a2)) ^ a2;
    m3 = xt(xt(xt(a3))) ^ a3;
    return m0 ^ m1 ^ m2 ^ m3;
  endfunction

  // rnd is 0 in FINAL, so the same selector yields key[0] for the last AddRoundKey.
  assign key_base  = KW'({rnd_reg, 7'b0});
  assign round_key = keys[key_base +: 128];

  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int R   = gi % 4;
    localparam int C   = gi / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    localparam int B1  = 4 * C + (R + 1) % 4;
    localparam int B2  = 4 * C + (R + 2) % 4;
    localparam int B3  = 4 * C + (R + 3) % 4;

    assign sub_row[8*gi +: 8] = INV_SBOX[{st_reg[8*SRC +: 8], 3'b000} +: 8];
    assign mix_in[8*gi +: 8]  = sub_row[8*gi +: 8] ^ round_key[8*gi +: 8];
    assign mix_out[8*gi +: 8] = inv_mix(mix_in[8*gi +: 8], mix_in[8*B1 +: 8],
                                        mix_in[8*B2 +: 8], mix_in[8*B3 +: 8]);
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      state_reg <= IDLE;
      st_reg    <= '0;
      plain_reg <= '0;
      rnd_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      st_reg    <= st_next;
      plain_reg <= plain_next;
      rnd_reg   <= rnd_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (start) state_next = ROUNDS;
      ROUNDS:  if (rnd_reg == 4'd1) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    st_next    = st_reg;
    plain_next = plain_reg;
    rnd_next   = rnd_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          st_next   = cipherText ^ keys[128*Nr +: 128];
          rnd_next  = 4'(Nr - 1);
          busy_next = 1'b1;
        end
      end
      ROUNDS: begin
        st_next  = mix_out;
        rnd_next = rnd_reg - 4'd1;
      end
      FINAL: begin
        plain_next = mix_in;
        done_next  = 1'b1;
        busy_next  = 1'b0;
      end
      default: ;
    endcase
  end

  assign plainText = plain_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: AES-128/192/256 instances against a byte-array AES model,
// FIPS-197 vectors, back-to-back handshake, mid-block reset and encrypt/decrypt round trips.
module tb_aes_inv_cipher_iter;

  logic         clks = 1'b0;
  logic         reset;
  logic         start_v [3];
  logic [0:127] ct_v    [3];
  logic [0:1919] keys_v [3];
  logic [0:127] pt_v    [3];
  logic         busy_v  [3];
  logic         done_v  [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  // Transaction-level model: cycles left until done per instance, 0 = idle.
  int           cnt_m  [3];
  logic [0:127] pend_m [3];
  logic [0:127] pt_m   [3];
  logic         busy_m [3];
  logic         done_m [3];

  localparam logic [0:127] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [0:127] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] CT3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [0:127] CT4 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [0:255] K2  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [0:255] K3  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [0:255] K4  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clks = ~clks;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    aes_inv_cipher_iter #(.Nk(4 + 2 * gi)) dut (
      .clks       (clks),
      .reset      (reset),
      .start      (start_v[gi]),
      .cipherText (ct_v[gi]),
      .keys       (keys_v[gi][0:128*(4+2*gi+7)-1]),
      .plainText  (pt_v[gi]),
      .busy       (busy_v[gi]),
      .done       (done_v[gi])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [0:1919] ks;
    int nw;
    nw = 4 * (nk + 7);
    ks = '0;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < nw; i++) ks[32*i +: 32] = w[i];
    return ks;
  endfunction

  function automatic logic [0:127] cipher(input logic [0:127] pt, input logic [0:1919] ks, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [0:127] res;
    for (int n = 0; n < 16; n++) s[n] = pt[8*n +: 8] ^ ks[8*n +: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[n%4 + 4*((n/4 + n%4) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = (r < nr) ? (gmul(t[4*c+j], 8'h02) ^ gmul(t[4*c+(j+1)%4], 8'h03) ^
                                 t[4*c+(j+2)%4] ^ t[4*c+(j+3)%4]) : t[4*c+j];
      for (int n = 0; n < 16; n++) s[n] = s[n] ^ ks[128*r + 8*n +: 8];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  function automatic logic [0:127] inv_cipher(input logic [0:127] ct, input logic [0:1919] ks, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [0:127] res;
    for (int n = 0; n < 16; n++) s[n] = ct[8*n +: 8] ^ ks[128*nr + 8*n +: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int n = 0; n < 16; n++)
        t[n] = isb[s[n%4 + 4*((n/4 - n%4 + 4) % 4)]] ^ ks[128*r + 8*n +: 8];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c+j] = (r > 0) ? (gmul(t[4*c+j], 8'h0e) ^ gmul(t[4*c+(j+1)%4], 8'h0b) ^
                                gmul(t[4*c+(j+2)%4], 8'h0d) ^ gmul(t[4*c+(j+3)%4], 8'h09)) : t[4*c+j];
    end
    for (int n = 0; n < 16; n++) res[8*n +: 8] = s[n];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        cnt_m[i] = 0; busy_m[i] = 1'b0; done_m[i] = 1'b0; pt_m[i] = '0;
      end else begin
        done_m[i] = 1'b0;
        if (cnt_m[i] > 0) begin
          cnt_m[i]--;
          if (cnt_m[i] == 0) begin
            done_m[i] = 1'b1; busy_m[i] = 1'b0; pt_m[i] = pend_m[i];
          end
        end else if (start_v[i]) begin
          pend_m[i] = inv_cipher(ct_v[i], keys_v[i], 10 + 2 * i);
          cnt_m[i]  = 10 + 2 * i;
          busy_m[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d busy cyc%0d", i, cyc), 128'(busy_v[i]), 128'(busy_m[i]));
      chk($sformatf("dut%0d done cyc%0d", i, cyc), 128'(done_v[i]), 128'(done_m[i]));
      chk($sformatf("dut%0d plainText cyc%0d", i, cyc), pt_v[i], pt_m[i]);
    end
  endtask

  // One block on instance i from idle; checks latency in edges (accept edge counted) and result.
  task automatic run_block(input int i, input logic [0:127] ct, input logic [0:1919] ks,
                           input logic [0:127] exp, input string name);
    int edges;
    bit seen;
    @(negedge clks);
    ct_v[i] = ct; keys_v[i] = ks; start_v[i] = 1'b1;
    @(posedge clks);
    edges = 1;
    @(negedge clks);
    start_v[i] = 1'b0;
    ct_v[i] = {$urandom, $urandom, $urandom, $urandom};
    seen = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clks);
      edges++;
      #1 seen = done_v[i];
    end
    chk({name, " latency"}, 128'(edges), 128'(11 + 2 * i));
    chk({name, " pt"}, pt_v[i], exp);
    $display("block %s dut%0d ct=%h pt=%h edges=%0d", name, i, ct, pt_v[i], edges);
  endtask

  initial begin
    logic [7:0]    inv, b;
    logic [0:1919] ks1, ks2, ks;
    logic [0:255]  key;
    logic [0:127]  pt, ct;
    int d1, d2, stage, dcount, inst;

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; ct_v[i] = '0; keys_v[i] = '0;
      cnt_m[i] = 0; pend_m[i] = '0; pt_m[i] = '0; busy_m[i] = 1'b0; done_m[i] = 1'b0;
    end

    // S-box from GF(2^8) inverse plus affine map; inverse table by inverting it.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      isb[sb[x]] = 8'(x);
    end

    ks1 = expand(K1, 4);
    ks2 = expand(K2, 4);
    chk("model ks2 round10", ks2[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model enc c1", cipher(PT0, ks1, 10), CT1);
    chk("model dec c1", inv_cipher(CT1, ks1, 10), PT0);
    chk("model dec b", inv_cipher(CT2, ks2, 10), PT2);
    chk("model dec 192", inv_cipher(CT3, expand(K3, 6), 12), PT0);
    chk("model dec 256", inv_cipher(CT4, expand(K4, 8), 14), PT0);

    fork
      forever begin
        @(posedge clks);
        model_step();
        #1 compare_all();
      end
    join_none

    @(posedge clks);
    #1;
    chk("reset busy", 128'(busy_v[0]), 128'(0));
    chk("reset done", 128'(done_v[0]), 128'(0));
    chk("reset pt", pt_v[0], 128'h0);
    repeat (2) @(posedge clks);
    @(negedge clks);
    reset = 1'b0;

    run_block(0, CT1, ks1, PT0, "fips_c1");
    run_block(0, CT2, ks2, PT2, "fips_b");
    run_block(1, CT3, expand(K3, 6), PT0, "fips_192");
    run_block(2, CT4, expand(K4, 8), PT0, "fips_256");

    // Back-to-back: each next block is accepted in the done cycle; start and cipherText
    // are randomised while busy and must be ignored.
    @(negedge clks);
    ct_v[0] = CT1; keys_v[0] = ks1; start_v[0] = 1'b1;
    d1 = -1; d2 = -1; stage = 0;
    for (int k = 0; k < 60 && stage < 3; k++) begin
      @(negedge clks);
      if (done_v[0]) begin
        if (stage == 0) begin
          chk("b2b first pt", pt_v[0], PT0);
          d1 = cyc; ct_v[0] = CT2; keys_v[0] = ks2; start_v[0] = 1'b1;
        end else if (stage == 1) begin
          chk("b2b second pt", pt_v[0], PT2);
          d2 = cyc; ct_v[0] = CT1; keys_v[0] = ks1; start_v[0] = 1'b1;
        end else begin
          chk("b2b third pt", pt_v[0], PT0);
          start_v[0] = 1'b0;
        end
        stage++;
      end else begin
        start_v[0] = 1'($urandom_range(0, 1));
        ct_v[0] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    start_v[0] = 1'b0;
    chk("b2b done count", 128'(stage), 128'(3));
    chk("b2b done spacing", 128'(d2 - d1), 128'(11));
    $display("b2b done pulses at cycles %0d and %0d", d1, d2);

    // Reset in the fifth cycle of a block, with start held high: block discarded.
    @(negedge clks);
    ct_v[0] = CT1; keys_v[0] = ks1; start_v[0] = 1'b1;
    @(negedge clks);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clks);
    reset = 1'b1; start_v[0] = 1'b1;
    @(posedge clks);
    #1;
    chk("mid reset busy", 128'(busy_v[0]), 128'(0));
    chk("mid reset done", 128'(done_v[0]), 128'(0));
    chk("mid reset pt", pt_v[0], 128'h0);
    @(negedge clks);
    reset = 1'b0; start_v[0] = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(posedge clks);
      #1 if (done_v[0]) dcount++;
    end
    chk("no done after reset", 128'(dcount), 128'(0));
    $display("reset mid-block: done pulses afterwards=%0d", dcount);
    run_block(0, CT1, ks1, PT0, "restart");

    // Round trips through the model encrypt path, spread over all three key sizes.
    for (int t = 0; t < 8; t++) begin
      inst = t % 3;
      for (int k = 0; k < 8; k++) key[32*k +: 32] = $urandom;
      pt = {$urandom, $urandom, $urandom, $urandom};
      ks = expand(key, 4 + 2 * inst);
      ct = cipher(pt, ks, 10 + 2 * inst);
      run_block(inst, ct, ks, pt, $sformatf("roundtrip%0d", t));
    end

    repeat (3) @(posedge clks);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
